// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch controller, slave = memory/decode/branch side.
interface imem_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, halted, fetch_count,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, halted, fetch_count,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, registers each fetched word with its PC for decode,
// accepts redirects, and halts on the zero word that marks end of program.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_fetch_ctrl_if.master bus
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic hs, load, zero_halt;

  assign hs        = out_valid_q & bus.out_ready;
  assign load      = (state_q == ST_FETCH) & (~out_valid_q | bus.out_ready) & ~bus.redirect_valid;
  assign zero_halt = HALT_ON_ZERO & (bus.imem_instr == 32'h0);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    halted_d      = halted_q;
    // A handshake coinciding with a redirect still consumed its word, so count it regardless.
    fetch_count_d = fetch_count_q + {31'd0, hs};

    if (bus.redirect_valid) begin
      pc_d        = {bus.redirect_pc[31:2], 2'b00};
      out_valid_d = 1'b0;
      state_d     = ST_FETCH;
      halted_d    = 1'b0;
    end else if (load) begin
      if (zero_halt) begin
        // PC stays on the zero word so the halt point is visible on imem_addr.
        state_d     = ST_HALT;
        halted_d    = 1'b1;
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        out_pc_d    = pc_q;
        out_instr_d = bus.imem_instr;
        pc_d        = pc_q + 32'd4;
      end
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_pc_q      <= 32'h0;
      out_instr_q   <= 32'h0;
      halted_q      <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a small program ROM, stalls, redirects, halt and wrap,
// plus a second instance built with HALT_ON_ZERO=0.
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  int   total = 0;
  int   bad   = 0;

  imem_fetch_ctrl_if b ();
  imem_fetch_ctrl_if c ();

  imem_fetch_ctrl #(.RESET_PC(32'h0), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.master));
  imem_fetch_ctrl #(.RESET_PC(32'hC), .HALT_ON_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst2_n), .bus(c.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h0050_0093;
      32'h0000_0004: rom = 32'h0010_0113;
      32'h0000_0008: rom = 32'h0020_81B3;
      32'h0000_0010: rom = 32'h0000_0013;
      32'h0000_0014: rom = 32'h0010_8093;
      32'hFFFF_FFFC: rom = 32'h0000_0513;
      default:       rom = 32'h0;
    endcase
  endfunction

  always_comb b.imem_instr = rom(b.imem_addr);
  always_comb c.imem_instr = rom(c.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, b.out_valid}, 32'd1);
    chk({tag, ".pc"}, b.out_pc, pc);
    chk({tag, ".instr"}, b.out_instr, ins);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    b.redirect_valid = 1'b0; b.redirect_pc = 32'h0; b.out_ready = 1'b1;
    c.redirect_valid = 1'b0; c.redirect_pc = 32'h0; c.out_ready = 1'b1;

    // reset state and straight-line run to halt
    tick();
    chk("rst.valid", {31'd0, b.out_valid}, 32'd0);
    chk("rst.addr", b.imem_addr, 32'h0);
    chk("rst.cnt", b.fetch_count, 32'd0);
    chk("rst.halted", {31'd0, b.halted}, 32'd0);
    chk("rst.out_pc", b.out_pc, 32'h0);
    chk("rst.out_instr", b.out_instr, 32'h0);
    rst_n = 1'b1;
    tick(); chk_out("run0", 32'h0, 32'h0050_0093);
    tick(); chk_out("run4", 32'h4, 32'h0010_0113); chk("run4.cnt", b.fetch_count, 32'd1);
    tick(); chk_out("run8", 32'h8, 32'h0020_81B3); chk("run8.cnt", b.fetch_count, 32'd2);
    tick();
    chk("halt.halted", {31'd0, b.halted}, 32'd1);
    chk("halt.valid", {31'd0, b.out_valid}, 32'd0);
    chk("halt.addr", b.imem_addr, 32'hC);
    chk("halt.cnt", b.fetch_count, 32'd3);
    tick();
    chk("halt.frozen", b.imem_addr, 32'hC);

    // stall with word at 0x4 presented
    rst_n = 1'b0; tick(); rst_n = 1'b1; b.out_ready = 1'b0;
    tick(); chk_out("st0", 32'h0, 32'h0050_0093);
    b.out_ready = 1'b1;
    tick(); chk_out("st4", 32'h4, 32'h0010_0113);
    b.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 32'h4, 32'h0010_0113);
      chk("stall.cnt", b.fetch_count, 32'd1);
      chk("stall.addr", b.imem_addr, 32'h8);
    end
    b.out_ready = 1'b1;
    tick(); chk_out("st8", 32'h8, 32'h0020_81B3); chk("st8.cnt", b.fetch_count, 32'd2);
    tick();
    chk("st.halted", {31'd0, b.halted}, 32'd1);
    chk("st.cnt", b.fetch_count, 32'd3);

    // redirect drops an unaccepted word
    rst_n = 1'b0; tick(); rst_n = 1'b1; b.out_ready = 1'b1;
    tick(); tick(); chk_out("rd4", 32'h4, 32'h0010_0113);
    b.out_ready = 1'b0; b.redirect_valid = 1'b1; b.redirect_pc = 32'h13;
    tick();
    chk("rd.valid", {31'd0, b.out_valid}, 32'd0);
    chk("rd.addr", b.imem_addr, 32'h10);
    chk("rd.cnt", b.fetch_count, 32'd1);
    b.redirect_valid = 1'b0;
    tick(); chk_out("rd10", 32'h10, 32'h0000_0013);
    chk("rd10.cnt", b.fetch_count, 32'd1);

    // redirect coincident with a handshake
    rst_n = 1'b0; tick(); rst_n = 1'b1; b.out_ready = 1'b1;
    tick(); tick(); tick(); chk_out("hs8", 32'h8, 32'h0020_81B3);
    b.redirect_valid = 1'b1; b.redirect_pc = 32'h10;
    tick();
    chk("rdhs.cnt", b.fetch_count, 32'd3);
    chk("rdhs.valid", {31'd0, b.out_valid}, 32'd0);
    chk("rdhs.addr", b.imem_addr, 32'h10);
    b.redirect_valid = 1'b0;
    tick(); chk_out("rdhs10", 32'h10, 32'h0000_0013);
    tick(); chk_out("rdhs14", 32'h14, 32'h0010_8093); chk("rdhs14.cnt", b.fetch_count, 32'd4);
    tick();
    chk("rdhs.halted", {31'd0, b.halted}, 32'd1);
    chk("rdhs.haddr", b.imem_addr, 32'h18);
    chk("rdhs.hcnt", b.fetch_count, 32'd5);

    // leave HALT via redirect
    b.redirect_valid = 1'b1; b.redirect_pc = 32'h0;
    tick();
    chk("unhalt.halted", {31'd0, b.halted}, 32'd0);
    chk("unhalt.valid", {31'd0, b.out_valid}, 32'd0);
    chk("unhalt.addr", b.imem_addr, 32'h0);
    b.redirect_valid = 1'b0;
    tick(); chk_out("unhalt0", 32'h0, 32'h0050_0093);

    // top-of-address-space wrap; low redirect bits are ignored
    b.out_ready = 1'b0; b.redirect_valid = 1'b1; b.redirect_pc = 32'hFFFF_FFFF;
    tick();
    chk("wrap.addr", b.imem_addr, 32'hFFFF_FFFC);
    chk("wrap.cnt", b.fetch_count, 32'd5);
    b.redirect_valid = 1'b0;
    tick(); chk_out("wrapw", 32'hFFFF_FFFC, 32'h0000_0513);
    chk("wrap.next", b.imem_addr, 32'h0);

    // reset mid-stream with a word presented
    rst_n = 1'b0;
    tick();
    chk("mrst.valid", {31'd0, b.out_valid}, 32'd0);
    chk("mrst.addr", b.imem_addr, 32'h0);
    chk("mrst.cnt", b.fetch_count, 32'd0);
    chk("mrst.halted", {31'd0, b.halted}, 32'd0);
    rst_n = 1'b1;

    // HALT_ON_ZERO=0 delivers the zero word
    chk("nz.rst_valid", {31'd0, c.out_valid}, 32'd0);
    rst2_n = 1'b1;
    tick();
    chk("nz.valid", {31'd0, c.out_valid}, 32'd1);
    chk("nz.pc", c.out_pc, 32'hC);
    chk("nz.instr", c.out_instr, 32'h0);
    chk("nz.halted", {31'd0, c.halted}, 32'd0);
    tick();
    chk("nz.pc2", c.out_pc, 32'h10);
    chk("nz.instr2", c.out_instr, 32'h0000_0013);
    chk("nz.cnt", c.fetch_count, 32'd1);
    chk("nz.halted2", {31'd0, c.halted}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
